// File: rtl/rename_resolver_n_if.sv
// Bus bundle between decode/rename-query, the resolve stage and the issuer.
// The resolver uses the slave view; the producer/consumer side uses the master view.
interface rename_resolver_n_if #(
    parameter int unsigned WIDTH        = 2,
    parameter int unsigned AREG_BITS    = 5,
    parameter int unsigned PREG_BITS    = 6,
    parameter int unsigned TAG_BITS     = 2,
    parameter int unsigned PAYLOAD_BITS = 96
);
    logic                          i_valid;
    logic                          o_ready;
    logic [WIDTH*AREG_BITS-1:0]    i_rd;
    logic [WIDTH*AREG_BITS-1:0]    i_rs1;
    logic [WIDTH*AREG_BITS-1:0]    i_rs2;
    logic [WIDTH-1:0]              i_writes;
    logic [WIDTH-1:0]              i_jumps;
    logic [WIDTH*PAYLOAD_BITS-1:0] i_payload;
    logic [WIDTH*PREG_BITS-1:0]    i_q_rs1;
    logic [WIDTH*PREG_BITS-1:0]    i_q_rs2;
    logic [WIDTH*PREG_BITS-1:0]    i_q_rn;
    logic [WIDTH-1:0]              i_q_rn_ok;
    logic [WIDTH-1:0]              o_alloc;
    logic                          o_valid;
    logic                          i_ready;
    logic [WIDTH*PREG_BITS-1:0]    o_rs1;
    logic [WIDTH*PREG_BITS-1:0]    o_rs2;
    logic [WIDTH*PREG_BITS-1:0]    o_rn;
    logic [WIDTH*AREG_BITS-1:0]    o_rd;
    logic [WIDTH-1:0]              o_writes;
    logic [WIDTH-1:0]              o_jumps;
    logic [WIDTH*TAG_BITS-1:0]     o_tag;
    logic [WIDTH*PAYLOAD_BITS-1:0] o_payload;
    logic [TAG_BITS-1:0]           o_depth;
    logic                          o_panic;

    modport slave (
        input  i_valid, i_rd, i_rs1, i_rs2, i_writes, i_jumps, i_payload,
               i_q_rs1, i_q_rs2, i_q_rn, i_q_rn_ok, i_ready,
        output o_ready, o_alloc, o_valid, o_rs1, o_rs2, o_rn, o_rd,
               o_writes, o_jumps, o_tag, o_payload, o_depth, o_panic
    );

    modport master (
        output i_valid, i_rd, i_rs1, i_rs2, i_writes, i_jumps, i_payload,
               i_q_rs1, i_q_rs2, i_q_rn, i_q_rn_ok, i_ready,
        input  o_ready, o_alloc, o_valid, o_rs1, o_rs2, o_rn, o_rd,
               o_writes, o_jumps, o_tag, o_payload, o_depth, o_panic
    );
endinterface

// File: rtl/rename_resolver_n.sv
// N-wide rename resolve stage: intra-group RAW forwarding, destination allocation,
// speculation-depth tagging, and a single registered output stage.
module rename_resolver_n #(
    parameter int unsigned WIDTH        = 2,
    parameter int unsigned AREG_BITS    = 5,
    parameter int unsigned PREG_BITS    = 6,
    parameter int unsigned TAG_BITS     = 2,
    parameter int unsigned MAX_DEPTH    = 3,
    parameter int unsigned PAYLOAD_BITS = 96
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 i_halt,
    input  logic                 i_flush,
    input  logic                 i_branch_resolve,
    rename_resolver_n_if.slave   bus
);
    localparam int unsigned CNT_BITS = $clog2(WIDTH + 1);
    localparam int unsigned SUM_BITS = TAG_BITS + CNT_BITS + 1;

    logic [WIDTH-1:0]              need;
    logic                          res_ok, depth_ok, ready, accept;
    logic [CNT_BITS-1:0]           jcnt;
    logic [SUM_BITS-1:0]           depth_sum, depth_eff;
    logic [PREG_BITS-1:0]          src1, src2;
    logic [TAG_BITS-1:0]           jprev;

    logic                          valid_q, valid_d;
    logic                          panic_q, panic_d;
    logic [TAG_BITS-1:0]           depth_q, depth_d;
    logic [WIDTH*PREG_BITS-1:0]    rs1_q, rs1_d, rs2_q, rs2_d, rn_q, rn_d;
    logic [WIDTH*TAG_BITS-1:0]     tag_q, tag_d;
    logic [WIDTH*AREG_BITS-1:0]    rd_q;
    logic [WIDTH-1:0]              writes_q, jumps_q;
    logic [WIDTH*PAYLOAD_BITS-1:0] payload_q;

    // Acceptance: every needed destination must be offered and depth must not overflow.
    always_comb begin
        need   = '0;
        res_ok = 1'b1;
        jcnt   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            need[i] = bus.i_writes[i] && (bus.i_rd[i*AREG_BITS +: AREG_BITS] != '0);
            if (need[i] && !bus.i_q_rn_ok[i]) res_ok = 1'b0;
            jcnt = jcnt + CNT_BITS'(bus.i_jumps[i]);
        end
        depth_sum = SUM_BITS'(depth_q) + SUM_BITS'(jcnt);
        depth_ok  = depth_sum <= SUM_BITS'(MAX_DEPTH);
        ready     = !reset && !i_halt && !i_flush && (!valid_q || bus.i_ready)
                    && res_ok && depth_ok;
        accept    = bus.i_valid && ready;
    end

    assign bus.o_ready = ready;
    assign bus.o_alloc = accept ? need : '0;

    // Source resolution: the youngest older writer in the group wins over the table.
    always_comb begin
        rs1_d = '0;
        rs2_d = '0;
        rn_d  = '0;
        tag_d = '0;
        src1  = '0;
        src2  = '0;
        jprev = depth_q;
        for (int i = 0; i < WIDTH; i++) begin
            src1 = bus.i_q_rs1[i*PREG_BITS +: PREG_BITS];
            src2 = bus.i_q_rs2[i*PREG_BITS +: PREG_BITS];
            for (int j = 0; j < WIDTH; j++) begin
                if (j < i && need[j]) begin
                    if (bus.i_rd[j*AREG_BITS +: AREG_BITS] == bus.i_rs1[i*AREG_BITS +: AREG_BITS])
                        src1 = bus.i_q_rn[j*PREG_BITS +: PREG_BITS];
                    if (bus.i_rd[j*AREG_BITS +: AREG_BITS] == bus.i_rs2[i*AREG_BITS +: AREG_BITS])
                        src2 = bus.i_q_rn[j*PREG_BITS +: PREG_BITS];
                end
            end
            rs1_d[i*PREG_BITS +: PREG_BITS] = src1;
            rs2_d[i*PREG_BITS +: PREG_BITS] = src2;
            rn_d[i*PREG_BITS +: PREG_BITS]  = need[i] ? bus.i_q_rn[i*PREG_BITS +: PREG_BITS] : '0;
            tag_d[i*TAG_BITS +: TAG_BITS]   = jprev;
            jprev = jprev + TAG_BITS'(bus.i_jumps[i]);
        end
    end

    // Output-valid and depth bookkeeping; a resolve with nothing in flight is a panic.
    always_comb begin
        valid_d   = valid_q;
        depth_d   = depth_q;
        panic_d   = panic_q;
        depth_eff = SUM_BITS'(depth_q) + (accept ? SUM_BITS'(jcnt) : '0);
        if (i_flush) begin
            valid_d = 1'b0;
            depth_d = '0;
        end else begin
            if (accept)           valid_d = 1'b1;
            else if (bus.i_ready) valid_d = 1'b0;
            if (i_branch_resolve) begin
                if (depth_eff != '0) depth_d = TAG_BITS'(depth_eff - SUM_BITS'(1));
                else                 panic_d = 1'b1;
            end else begin
                depth_d = TAG_BITS'(depth_eff);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q   <= 1'b0;
            panic_q   <= 1'b0;
            depth_q   <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rn_q      <= '0;
            tag_q     <= '0;
            rd_q      <= '0;
            writes_q  <= '0;
            jumps_q   <= '0;
            payload_q <= '0;
        end else begin
            valid_q <= valid_d;
            panic_q <= panic_d;
            depth_q <= depth_d;
            if (accept) begin
                rs1_q     <= rs1_d;
                rs2_q     <= rs2_d;
                rn_q      <= rn_d;
                tag_q     <= tag_d;
                rd_q      <= bus.i_rd;
                writes_q  <= bus.i_writes;
                jumps_q   <= bus.i_jumps;
                payload_q <= bus.i_payload;
            end
        end
    end

    assign bus.o_valid   = valid_q;
    assign bus.o_rs1     = rs1_q;
    assign bus.o_rs2     = rs2_q;
    assign bus.o_rn      = rn_q;
    assign bus.o_tag     = tag_q;
    assign bus.o_rd      = rd_q;
    assign bus.o_writes  = writes_q;
    assign bus.o_jumps   = jumps_q;
    assign bus.o_payload = payload_q;
    assign bus.o_depth   = depth_q;
    assign bus.o_panic   = panic_q;
endmodule

// File: tb/tb_rename_resolver_n.sv
// Directed bench for rename_resolver_n (WIDTH=4): forwarding, allocation, depth
// stalls, backpressure, flush and panic, against hand-computed expectations.
module tb_rename_resolver_n;
    localparam int unsigned W  = 4;
    localparam int unsigned A  = 5;
    localparam int unsigned P  = 6;
    localparam int unsigned T  = 2;
    localparam int unsigned D  = 3;
    localparam int unsigned PL = 96;

    logic clock = 1'b0;
    logic reset, halt, flush, resolve;
    int   n_cmp = 0;
    int   n_bad = 0;

    rename_resolver_n_if #(.WIDTH(W), .AREG_BITS(A), .PREG_BITS(P), .TAG_BITS(T),
                           .PAYLOAD_BITS(PL)) bus ();

    rename_resolver_n #(.WIDTH(W), .AREG_BITS(A), .PREG_BITS(P), .TAG_BITS(T),
                        .MAX_DEPTH(D), .PAYLOAD_BITS(PL)) dut (
        .clock            (clock),
        .reset            (reset),
        .i_halt           (halt),
        .i_flush          (flush),
        .i_branch_resolve (resolve),
        .bus              (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic clear_in();
        bus.i_valid   = 1'b0;
        bus.i_rd      = '0;
        bus.i_rs1     = '0;
        bus.i_rs2     = '0;
        bus.i_writes  = '0;
        bus.i_jumps   = '0;
        bus.i_payload = '0;
        bus.i_q_rs1   = '0;
        bus.i_q_rs2   = '0;
        bus.i_q_rn    = '0;
        bus.i_q_rn_ok = '1;
    endtask

    task automatic set_slot(input int s, input logic [A-1:0] rd, input logic [A-1:0] rs1,
                            input logic [A-1:0] rs2, input logic wr, input logic [P-1:0] qrs1,
                            input logic [P-1:0] qrs2, input logic [P-1:0] qrn);
        bus.i_rd[s*A +: A]    = rd;
        bus.i_rs1[s*A +: A]   = rs1;
        bus.i_rs2[s*A +: A]   = rs2;
        bus.i_writes[s]       = wr;
        bus.i_q_rs1[s*P +: P] = qrs1;
        bus.i_q_rs2[s*P +: P] = qrs2;
        bus.i_q_rn[s*P +: P]  = qrn;
    endtask

    initial begin
        reset = 1'b1; halt = 1'b0; flush = 1'b0; resolve = 1'b0;
        bus.i_ready = 1'b1;
        clear_in();
        @(negedge clock);
        cyc();
        #1 check("rst_ready", bus.o_ready, 1'b0);
        reset = 1'b0;
        #1;
        check("rst_valid", bus.o_valid, 1'b0);
        check("rst_depth", bus.o_depth, 2'd0);
        check("rst_panic", bus.o_panic, 1'b0);
        check("rst_tag", bus.o_tag, 8'h00);
        check("idle_ready", bus.o_ready, 1'b1);

        // Slot 1 reads the register slot 0 writes in the same group
        set_slot(0, 5'd3, 5'd0, 5'd0, 1'b1, 6'd0, 6'd0, 6'd40);
        set_slot(1, 5'd0, 5'd3, 5'd4, 1'b0, 6'd9, 6'd17, 6'd0);
        bus.i_payload[0 +: PL] = 96'h1234_5678;
        bus.i_valid = 1'b1;
        #1;
        check("t1_alloc", bus.o_alloc, 4'b0001);
        check("t1_ready", bus.o_ready, 1'b1);
        cyc();
        clear_in();
        check("t1_valid", bus.o_valid, 1'b1);
        check("t1_rs1_1", bus.o_rs1[1*P +: P], 6'd40);
        check("t1_rs2_1", bus.o_rs2[1*P +: P], 6'd17);
        check("t1_rn_0", bus.o_rn[0 +: P], 6'd40);
        check("t1_rn_1", bus.o_rn[1*P +: P], 6'd0);
        check("t1_rd_0", bus.o_rd[0 +: A], 5'd3);
        check("t1_payload", bus.o_payload[0 +: PL], 96'h1234_5678);

        // Two older writers of the same register: the younger one forwards
        set_slot(0, 5'd5, 5'd0, 5'd0, 1'b1, 6'd0, 6'd0, 6'd33);
        set_slot(2, 5'd5, 5'd0, 5'd0, 1'b1, 6'd0, 6'd0, 6'd35);
        set_slot(3, 5'd0, 5'd5, 5'd0, 1'b0, 6'd7, 6'd0, 6'd0);
        bus.i_valid = 1'b1;
        #1 check("t2_alloc", bus.o_alloc, 4'b0101);
        cyc();
        check("t2_rs1_3", bus.o_rs1[3*P +: P], 6'd35);
        check("t2_rn_2", bus.o_rn[2*P +: P], 6'd35);

        // Same group writing x0: no forwarding, no allocation
        set_slot(0, 5'd0, 5'd0, 5'd0, 1'b1, 6'd0, 6'd0, 6'd33);
        set_slot(2, 5'd0, 5'd0, 5'd0, 1'b1, 6'd0, 6'd0, 6'd35);
        set_slot(3, 5'd0, 5'd0, 5'd0, 1'b0, 6'd7, 6'd0, 6'd0);
        #1 check("t3_alloc", bus.o_alloc, 4'b0000);
        cyc();
        clear_in();
        check("t3_rs1_3", bus.o_rs1[3*P +: P], 6'd7);
        check("t3_rn_0", bus.o_rn[0 +: P], 6'd0);
        check("t3_rn_2", bus.o_rn[2*P +: P], 6'd0);

        // Jump in slot 0: younger slots carry depth+1
        bus.i_jumps = 4'b0001;
        bus.i_valid = 1'b1;
        cyc();
        clear_in();
        check("t4_tag", bus.o_tag, 8'h54);
        check("t4_depth", bus.o_depth, 2'd1);
        check("t4_jumps", bus.o_jumps, 4'b0001);

        // Single-jump groups until MAX_DEPTH is reached
        bus.i_jumps = 4'b0001;
        set_slot(0, 5'd2, 5'd0, 5'd0, 1'b1, 6'd0, 6'd0, 6'd12);
        bus.i_valid = 1'b1;
        cyc();
        cyc();
        check("dep_full", bus.o_depth, 2'd3);
        #1;
        check("dep_stall_ready", bus.o_ready, 1'b0);
        check("dep_stall_alloc", bus.o_alloc, 4'b0000);
        resolve = 1'b1;
        #1 check("dep_resolve_not_credited", bus.o_ready, 1'b0);
        cyc();
        resolve = 1'b0;
        #1;
        check("dep_after_resolve", bus.o_depth, 2'd2);
        check("dep_release_ready", bus.o_ready, 1'b1);
        check("dep_release_alloc", bus.o_alloc, 4'b0001);
        cyc();
        clear_in();
        check("dep_refill", bus.o_depth, 2'd3);
        check("dep_tag", bus.o_tag, 8'hFE);

        // Backpressure: output holds while a new group waits
        bus.i_ready = 1'b0;
        set_slot(0, 5'd7, 5'd0, 5'd0, 1'b1, 6'd0, 6'd0, 6'd50);
        bus.i_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("bp_valid", bus.o_valid, 1'b1);
            check("bp_tag", bus.o_tag, 8'hFE);
            check("bp_rn0", bus.o_rn[0 +: P], 6'd12);
            check("bp_ready", bus.o_ready, 1'b0);
            check("bp_alloc", bus.o_alloc, 4'b0000);
            cyc();
        end
        bus.i_ready = 1'b1;
        #1;
        check("bp_release_ready", bus.o_ready, 1'b1);
        check("bp_release_alloc", bus.o_alloc, 4'b0001);
        cyc();
        clear_in();
        check("b2b_valid", bus.o_valid, 1'b1);
        check("b2b_rn0", bus.o_rn[0 +: P], 6'd50);
        check("b2b_tag", bus.o_tag, 8'hFF);
        cyc();
        check("drain_valid", bus.o_valid, 1'b0);

        // Missing free register stalls; dropping the write lets it through
        set_slot(1, 5'd8, 5'd0, 5'd0, 1'b1, 6'd0, 6'd0, 6'd20);
        bus.i_q_rn_ok[1] = 1'b0;
        bus.i_valid = 1'b1;
        #1;
        check("resok_ready", bus.o_ready, 1'b0);
        check("resok_alloc", bus.o_alloc, 4'b0000);
        bus.i_writes[1] = 1'b0;
        #1;
        check("resok_nowrite_ready", bus.o_ready, 1'b1);
        check("resok_nowrite_alloc", bus.o_alloc, 4'b0000);
        cyc();
        clear_in();
        check("resok_valid", bus.o_valid, 1'b1);
        check("resok_rn1", bus.o_rn[1*P +: P], 6'd0);

        // Flush with depth 2 and a valid output; concurrent resolve is ignored
        bus.i_ready = 1'b0;
        resolve = 1'b1;
        cyc();
        resolve = 1'b0;
        check("pre_flush_depth", bus.o_depth, 2'd2);
        check("pre_flush_valid", bus.o_valid, 1'b1);
        flush = 1'b1;
        resolve = 1'b1;
        bus.i_valid = 1'b1;
        #1 check("flush_alloc", bus.o_alloc, 4'b0000);
        cyc();
        flush = 1'b0;
        resolve = 1'b0;
        clear_in();
        bus.i_ready = 1'b1;
        check("flush_valid", bus.o_valid, 1'b0);
        check("flush_depth", bus.o_depth, 2'd0);
        check("flush_panic", bus.o_panic, 1'b0);

        // Accept a jump and resolve it in the same cycle
        bus.i_jumps = 4'b0001;
        bus.i_valid = 1'b1;
        resolve = 1'b1;
        cyc();
        resolve = 1'b0;
        clear_in();
        check("same_cyc_depth", bus.o_depth, 2'd0);
        check("same_cyc_panic", bus.o_panic, 1'b0);
        check("same_cyc_tag", bus.o_tag, 8'h54);

        // Resolve with nothing in flight: sticky panic
        resolve = 1'b1;
        cyc();
        resolve = 1'b0;
        check("panic_set", bus.o_panic, 1'b1);
        check("panic_depth", bus.o_depth, 2'd0);
        cyc();
        cyc();
        check("panic_sticky", bus.o_panic, 1'b1);

        // Halt blocks acceptance
        halt = 1'b1;
        set_slot(0, 5'd9, 5'd0, 5'd0, 1'b1, 6'd0, 6'd0, 6'd21);
        bus.i_valid = 1'b1;
        #1;
        check("halt_ready", bus.o_ready, 1'b0);
        check("halt_alloc", bus.o_alloc, 4'b0000);
        halt = 1'b0;

        // Reset while a group is offered
        reset = 1'b1;
        #1 check("midrst_alloc", bus.o_alloc, 4'b0000);
        cyc();
        reset = 1'b0;
        clear_in();
        check("midrst_valid", bus.o_valid, 1'b0);
        check("midrst_panic", bus.o_panic, 1'b0);
        check("midrst_depth", bus.o_depth, 2'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
